// File: rtl/vc_src_arb_pkg.sv
// Shared defaults and helpers for the vc source-side arbiter and its picker.
// Imported by the arbiter, the picker and the link interface.
package vc_src_arb_pkg;

    localparam int INPUTS_DEF  = 4;
    localparam int WIDTH_DEF   = 8;
    localparam int CREDITS_DEF = 16;

    function automatic int rr_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/vc_src_arb_if.sv
// Requester handshake, vc link and credit status bundled for the source arbiter.
// The slave side is the arbiter; the master side is whoever drives requests and returns credits.
interface vc_src_arb_if #(
    parameter int inputs  = 4,
    parameter int width   = 8,
    parameter int credits = 16,
    parameter int csz     = $clog2(credits + 1)
);

    logic [inputs-1:0]       c_srdy;
    logic [inputs-1:0]       c_drdy;
    logic [inputs*width-1:0] c_data;
    logic                    p_vld;
    logic [width-1:0]        p_data;
    logic                    p_cr;
    logic [csz-1:0]          credit_cnt;
    logic                    credit_err;

    modport slave (
        input  c_srdy, c_data, p_cr,
        output c_drdy, p_vld, p_data, credit_cnt, credit_err
    );

    modport master (
        output c_srdy, c_data, p_cr,
        input  c_drdy, p_vld, p_data, credit_cnt, credit_err
    );

endinterface

// File: rtl/sd_rrmux_arb.sv
// Combinational round-robin picker: searches req starting one past ptr, wrapping,
// and returns the first hit as a one-hot grant plus its encoded index.
module sd_rrmux_arb
    import vc_src_arb_pkg::*;
#(
    parameter int inputs = INPUTS_DEF,
    parameter int pw     = (inputs > 1) ? $clog2(inputs) : 1
) (
    input  logic [inputs-1:0] req,
    input  logic [pw-1:0]     ptr,
    output logic [inputs-1:0] gnt,
    output logic [pw-1:0]     idx,
    output logic              any
);

    always_comb begin
        gnt = '0;
        idx = ptr;
        any = 1'b0;
        for (int off = 1; off <= inputs; off++) begin
            if (!any && req[rr_idx(int'(ptr), off, inputs)]) begin
                any = 1'b1;
                gnt[rr_idx(int'(ptr), off, inputs)] = 1'b1;
                idx = pw'(rr_idx(int'(ptr), off, inputs));
            end
        end
    end

endmodule

// File: rtl/vc_src_arb.sv
// Round-robin arbiter with credit control feeding one valid/credit link.
// A requester is granted only while the registered credit count is non-zero.
module vc_src_arb
    import vc_src_arb_pkg::*;
#(
    parameter int inputs  = INPUTS_DEF,
    parameter int width   = WIDTH_DEF,
    parameter int credits = CREDITS_DEF,
    parameter int csz     = $clog2(credits + 1)
) (
    input logic         clk,
    input logic         reset,
    vc_src_arb_if.slave vc
);

    localparam int pw = (inputs > 1) ? $clog2(inputs) : 1;

    logic [pw-1:0]     ptr;
    logic [inputs-1:0] gnt;
    logic [pw-1:0]     win_idx;
    logic              any_req;
    logic              credit_ok;
    logic              grant;
    logic              ovf;
    logic [csz-1:0]    cnt_nxt;

    sd_rrmux_arb #(.inputs(inputs), .pw(pw)) u_pick (
        .req (vc.c_srdy),
        .ptr (ptr),
        .gnt (gnt),
        .idx (win_idx),
        .any (any_req)
    );

    // Eligibility looks only at the registered count, so drdy never depends on p_cr.
    assign credit_ok = (vc.credit_cnt != '0);
    assign grant     = credit_ok & any_req;
    assign vc.c_drdy = credit_ok ? gnt : '0;
    assign ovf       = !grant && vc.p_cr && (vc.credit_cnt == csz'(credits));

    always_comb begin
        cnt_nxt = vc.credit_cnt;
        case ({grant, vc.p_cr})
            2'b10:   cnt_nxt = vc.credit_cnt - csz'(1);
            2'b01:   if (!ovf) cnt_nxt = vc.credit_cnt + csz'(1);
            default: cnt_nxt = vc.credit_cnt;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vc.p_vld      <= 1'b0;
            vc.p_data     <= '0;
            vc.credit_cnt <= csz'(credits);
            vc.credit_err <= 1'b0;
            ptr           <= pw'(inputs - 1);
        end else begin
            vc.p_vld      <= grant;
            vc.credit_cnt <= cnt_nxt;
            if (grant) begin
                vc.p_data <= vc.c_data[win_idx*width +: width];
                ptr       <= win_idx;
            end
            if (ovf) vc.credit_err <= 1'b1;
        end
    end

    // The receiver returned more credits than it was ever given.
    ovf_chk: assert property (@(posedge clk) disable iff (reset) !ovf)
        else $warning("vc_src_arb: credit returned while count already full");

endmodule

// File: tb/tb_vc_src_arb.sv
// Directed bench for vc_src_arb: vector table for arbitration/credit tracking
// plus hand-written burst, credit-edge, overflow and async-reset sequences.
module tb_vc_src_arb;

    localparam int INPUTS  = 4;
    localparam int WIDTH   = 8;
    localparam int CREDITS = 16;
    localparam int CSZ     = $clog2(CREDITS + 1);

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    vc_src_arb_if #(.inputs(INPUTS), .width(WIDTH), .credits(CREDITS), .csz(CSZ)) vc ();

    vc_src_arb #(.inputs(INPUTS), .width(WIDTH), .credits(CREDITS), .csz(CSZ)) dut (
        .clk   (clk),
        .reset (reset),
        .vc    (vc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] srdy;
        logic       pcr;
        logic [3:0] drdy;
        logic       vld;
        logic [7:0] data;
        logic [4:0] cnt;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Starting state: ptr=3, cnt=16; c_data[i] = 0x10+i.
        tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 8'h10, 5'd15};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 5'd15};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 5'd15};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 8'h13, 5'd15};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 5'd15};
        tbl[5]  = '{4'b1010, 1'b0, 4'b0010, 1'b1, 8'h11, 5'd14};
        tbl[6]  = '{4'b1010, 1'b0, 4'b1000, 1'b1, 8'h13, 5'd13};
        tbl[7]  = '{4'b1010, 1'b0, 4'b0010, 1'b1, 8'h11, 5'd12};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 5'd13};
        tbl[9]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'h12, 5'd13};
        tbl[10] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 8'h10, 5'd13};
        tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h10, 5'd14};
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h10, 5'd15};
        tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h10, 5'd16};

        reset     = 1'b1;
        vc.c_srdy = '0;
        vc.c_data = {8'h13, 8'h12, 8'h11, 8'h10};
        vc.p_cr   = 1'b0;
        #12;
        chk("rst_vld", 32'(vc.p_vld), 32'd0);
        chk("rst_data", 32'(vc.p_data), 32'd0);
        chk("rst_cnt", 32'(vc.credit_cnt), 32'd16);
        chk("rst_err", 32'(vc.credit_err), 32'd0);
        cyc();
        reset = 1'b0;

        // Idle: nothing requested, nothing changes.
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("idle_drdy", 32'(vc.c_drdy), 32'd0);
            chk("idle_vld", 32'(vc.p_vld), 32'd0);
            chk("idle_cnt", 32'(vc.credit_cnt), 32'd16);
        end
        chk("idle_err", 32'(vc.credit_err), 32'd0);

        for (int i = 0; i < 14; i++) begin
            vc.c_srdy = tbl[i].srdy;
            vc.p_cr   = tbl[i].pcr;
            #1;
            chk($sformatf("tbl%0d_drdy", i), 32'(vc.c_drdy), 32'(tbl[i].drdy));
            cyc();
            chk($sformatf("tbl%0d_vld", i), 32'(vc.p_vld), 32'(tbl[i].vld));
            chk($sformatf("tbl%0d_data", i), 32'(vc.p_data), 32'(tbl[i].data));
            chk($sformatf("tbl%0d_cnt", i), 32'(vc.credit_cnt), 32'(tbl[i].cnt));
        end

        // Fresh start, then a single requester drains all credits.
        vc.c_srdy = '0;
        vc.p_cr   = 1'b0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        vc.c_srdy = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            vc.c_data[7:0] = 8'(8'h40 + k);
            #1;
            chk($sformatf("burst%0d_drdy", k), 32'(vc.c_drdy), 32'b0001);
            cyc();
            chk($sformatf("burst%0d_vld", k), 32'(vc.p_vld), 32'd1);
            chk($sformatf("burst%0d_data", k), 32'(vc.p_data), 32'(8'h40 + k));
            chk($sformatf("burst%0d_cnt", k), 32'(vc.credit_cnt), 32'(15 - k));
        end
        #1;
        chk("empty_drdy", 32'(vc.c_drdy), 32'd0);
        cyc();
        chk("empty_vld", 32'(vc.p_vld), 32'd0);
        chk("empty_cnt", 32'(vc.credit_cnt), 32'd0);
        chk("empty_data_hold", 32'(vc.p_data), 32'h4f);

        // Credit return at count 0 must not enable a grant in that same cycle.
        vc.p_cr = 1'b1;
        #1;
        chk("cr0_drdy", 32'(vc.c_drdy), 32'd0);
        cyc();
        chk("cr0_vld", 32'(vc.p_vld), 32'd0);
        chk("cr0_cnt", 32'(vc.credit_cnt), 32'd1);
        vc.c_data[7:0] = 8'h55;
        #1;
        chk("cr1_drdy", 32'(vc.c_drdy), 32'b0001);
        cyc();
        chk("cr1_vld", 32'(vc.p_vld), 32'd1);
        chk("cr1_data", 32'(vc.p_data), 32'h55);
        chk("cr1_cnt", 32'(vc.credit_cnt), 32'd1);
        vc.p_cr = 1'b0;
        cyc();
        chk("cr2_vld", 32'(vc.p_vld), 32'd1);
        chk("cr2_cnt", 32'(vc.credit_cnt), 32'd0);
        vc.c_srdy = '0;

        // Refill to full, then one extra credit trips the sticky error.
        vc.p_cr = 1'b1;
        repeat (16) cyc();
        chk("full_cnt", 32'(vc.credit_cnt), 32'd16);
        chk("full_err", 32'(vc.credit_err), 32'd0);
        cyc();
        chk("ovf_cnt", 32'(vc.credit_cnt), 32'd16);
        chk("ovf_err", 32'(vc.credit_err), 32'd1);
        vc.p_cr = 1'b0;
        cyc();
        chk("ovf_err_sticky", 32'(vc.credit_err), 32'd1);

        // Async reset in the middle of a burst.
        vc.c_srdy = 4'b1111;
        vc.c_data = {8'h13, 8'h12, 8'h11, 8'h10};
        cyc();
        cyc();
        chk("pre_rst_vld", 32'(vc.p_vld), 32'd1);
        chk("pre_rst_cnt", 32'(vc.credit_cnt), 32'd14);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_vld", 32'(vc.p_vld), 32'd0);
        chk("arst_cnt", 32'(vc.credit_cnt), 32'd16);
        chk("arst_err", 32'(vc.credit_err), 32'd0);
        chk("arst_drdy", 32'(vc.c_drdy), 32'b0001);
        cyc();
        reset = 1'b0;
        vc.c_srdy = '0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
